// File: rtl/async_fifo_pkg.sv
// Shared constants and types for the FIFO family.
//   FIFO_DATA_WIDTH       default word width
//   SYNC_FIFO_ADDR_WIDTH  default sync FIFO address width (depth = 2**N)
//   SYNC_FIFO_AFULL       default almost-full threshold (count >= value)
//   SYNC_FIFO_AEMPTY      default almost-empty threshold (count <= value)
//   fifo_rd_mode_e        read-mode encoding (registered / first-word-fall-through)
package async_fifo_pkg;

  localparam int FIFO_DATA_WIDTH      = 8;

  localparam int SYNC_FIFO_ADDR_WIDTH = 4;
  localparam int SYNC_FIFO_AFULL      = 12;
  localparam int SYNC_FIFO_AEMPTY     = 4;

  typedef enum {FIFO_STD, FIFO_FWFT} fifo_rd_mode_e;

endpackage

// File: rtl/sync_fifo_flagged_if.sv
// Push/pop bundle for sync_fifo_flagged.
//   master: drives winc/wdata/rinc/clr_err, observes data, flags and count
//   slave : the FIFO side
//   winc/wdata/wfull/wafull  write side
//   rinc/rdata/rempty/raempty read side
//   count                    stored words, 0..2**ADDR_WIDTH
//   overflow/underflow       sticky error flags, cleared by clr_err
interface sync_fifo_flagged_if
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = SYNC_FIFO_ADDR_WIDTH
);
  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wfull;
  logic                  wafull;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rempty;
  logic                  raempty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;

  modport master (
    output winc, wdata, rinc, clr_err,
    input  wfull, wafull, rdata, rempty, raempty, count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc, clr_err,
    output wfull, wafull, rdata, rempty, raempty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_mem.sv
// Register-array dual-port storage for sync_fifo_flagged.
//   clk    write clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address (asynchronous read)
//   rdata  read data
// Contents are intentionally not reset.
module sync_fifo_mem
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = SYNC_FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with almost-full/almost-empty thresholds, fill count,
// sticky overflow/underflow flags and selectable first-word-fall-through read.
//   clk    clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    push/pop bundle (slave side), see sync_fifo_flagged_if
// Parameters: DATA_WIDTH, ADDR_WIDTH (depth 2**ADDR_WIDTH), AFULL_THRESH
// (1..DEPTH), AEMPTY_THRESH (0..DEPTH-1), FWFT (0 registered read, 1 FWFT).
module sync_fifo_flagged
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH    = SYNC_FIFO_ADDR_WIDTH,
  parameter int AFULL_THRESH  = SYNC_FIFO_AFULL,
  parameter int AEMPTY_THRESH = SYNC_FIFO_AEMPTY,
  parameter int FWFT          = 0
) (
  input logic               clk,
  input logic               rst_n,
  sync_fifo_flagged_if.slave bus
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_THRESH);

  localparam fifo_rd_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_flagged: AFULL_THRESH %0d outside 1..%0d", AFULL_THRESH, DEPTH);
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_flagged: AEMPTY_THRESH %0d outside 0..%0d", AEMPTY_THRESH, DEPTH - 1);
  end
  if (FWFT < 0 || FWFT > 1) begin : g_bad_fwft
    $error("sync_fifo_flagged: FWFT %0d must be 0 or 1", FWFT);
  end

  logic [PW-1:0]         wptr, rptr, count_r;
  logic [PW-1:0]         wptr_nxt, rptr_nxt, count_nxt;
  logic                  wfull_r, wafull_r, rempty_r, raempty_r;
  logic                  ovf_r, udf_r;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] mem_rdata, rdata_r;

  // Acceptance uses only the registered flags; no write-to-read bypass.
  always_comb begin
    wr_ok     = bus.winc && !wfull_r;
    rd_ok     = bus.rinc && !rempty_r;
    wptr_nxt  = wptr + PW'(wr_ok);
    rptr_nxt  = rptr + PW'(rd_ok);
    count_nxt = wptr_nxt - rptr_nxt;
  end

  sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wptr[ADDR_WIDTH-1:0]),
    .wdata(bus.wdata),
    .raddr(rptr[ADDR_WIDTH-1:0]),
    .rdata(mem_rdata)
  );

  // Pointers, count and flags all step together from the next-state count,
  // so every flag is consistent with count in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count_r   <= '0;
      wfull_r   <= 1'b0;
      wafull_r  <= 1'b0;
      rempty_r  <= 1'b1;
      raempty_r <= 1'b1;
      ovf_r     <= 1'b0;
      udf_r     <= 1'b0;
    end else begin
      wptr      <= wptr_nxt;
      rptr      <= rptr_nxt;
      count_r   <= count_nxt;
      wfull_r   <= (count_nxt == DEPTH_C);
      wafull_r  <= (count_nxt >= AFULL_C);
      rempty_r  <= (count_nxt == '0);
      raempty_r <= (count_nxt <= AEMPTY_C);
      // A new error in the same cycle as clr_err wins over the clear.
      ovf_r     <= (bus.winc && wfull_r) || (ovf_r && !bus.clr_err);
      udf_r     <= (bus.rinc && rempty_r) || (udf_r && !bus.clr_err);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata_r <= '0;
    else if (rd_ok) rdata_r <= mem_rdata;
  end

  // FWFT shows the head word directly; it is forced to zero while empty so
  // the output never exposes stale or uninitialised storage.
  always_comb begin
    if (MODE == FIFO_FWFT) bus.rdata = rempty_r ? '0 : mem_rdata;
    else                   bus.rdata = rdata_r;
  end

  assign bus.wfull     = wfull_r;
  assign bus.wafull    = wafull_r;
  assign bus.rempty    = rempty_r;
  assign bus.raempty   = raempty_r;
  assign bus.count     = count_r;
  assign bus.overflow  = ovf_r;
  assign bus.underflow = udf_r;
endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Self-checking bench for sync_fifo_flagged: a registered-read instance
// driven by a vector table plus scoreboard, and an FWFT instance exercised
// by a short hand-written sequence.
module tb_sync_fifo_flagged;
  import async_fifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_flagged_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s_if ();
  sync_fifo_flagged_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) f_if ();

  sync_fifo_flagged #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(12), .AEMPTY_THRESH(4), .FWFT(0)
  ) u_std (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (s_if.slave)
  );

  sync_fifo_flagged #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(12), .AEMPTY_THRESH(4), .FWFT(1)
  ) u_fwft (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (f_if.slave)
  );

  typedef struct {
    logic          winc;
    logic [DW-1:0] wdata;
    logic          rinc;
    logic          clr;
    int            cnt;
    logic          full;
    logic          afull;
    logic          empty;
    logic          aempty;
    logic          ovf;
    logic          udf;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] sb[$];
  int            checks = 0;
  int            errors = 0;

  function automatic vec_t mkvec(logic w, logic [DW-1:0] d, logic r, logic c,
                                 int cnt, logic ovf, logic udf);
    vec_t v;
    v.winc   = w;
    v.wdata  = d;
    v.rinc   = r;
    v.clr    = c;
    v.cnt    = cnt;
    v.full   = (cnt == DEPTH);
    v.afull  = (cnt >= 12);
    v.empty  = (cnt == 0);
    v.aempty = (cnt <= 4);
    v.ovf    = ovf;
    v.udf    = udf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock on the registered-read instance; the scoreboard decides from
  // its own occupancy whether the write/read should be accepted.
  task automatic step_std(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    logic [DW-1:0] exp_d;
    bit            do_rd, do_wr;
    do_rd = r && (sb.size() > 0);
    do_wr = w && (sb.size() < DEPTH);
    exp_d = do_rd ? sb[0] : '0;
    s_if.winc    = w;
    s_if.wdata   = d;
    s_if.rinc    = r;
    s_if.clr_err = c;
    @(posedge clk);
    #1;
    if (do_rd) begin
      void'(sb.pop_front());
      chk("rdata", {24'd0, s_if.rdata}, {24'd0, exp_d});
    end
    if (do_wr) sb.push_back(d);
    s_if.winc    = 1'b0;
    s_if.rinc    = 1'b0;
    s_if.clr_err = 1'b0;
  endtask

  initial begin
    s_if.winc = 0; s_if.wdata = '0; s_if.rinc = 0; s_if.clr_err = 0;
    f_if.winc = 0; f_if.wdata = '0; f_if.rinc = 0; f_if.clr_err = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst count",     {27'd0, s_if.count}, 0);
    chk("rst rempty",    {31'd0, s_if.rempty}, 1);
    chk("rst raempty",   {31'd0, s_if.raempty}, 1);
    chk("rst wfull",     {31'd0, s_if.wfull}, 0);
    chk("rst wafull",    {31'd0, s_if.wafull}, 0);
    chk("rst rdata",     {24'd0, s_if.rdata}, 0);
    chk("rst overflow",  {31'd0, s_if.overflow}, 0);
    chk("rst underflow", {31'd0, s_if.underflow}, 0);
    chk("rst f rempty",  {31'd0, f_if.rempty}, 1);
    rst_n = 1'b1;

    // Vector table: fill, overflow, clear, drain, simultaneous on empty
    for (int i = 0; i < DEPTH; i++) vecs.push_back(mkvec(1, DW'(i), 0, 0, i + 1, 0, 0));
    vecs.push_back(mkvec(1, 8'hAA, 0, 0, 16, 1, 0));
    vecs.push_back(mkvec(0, 8'h00, 0, 1, 16, 0, 0));
    for (int i = 0; i < DEPTH; i++) vecs.push_back(mkvec(0, 8'h00, 1, 0, 15 - i, 0, 0));
    vecs.push_back(mkvec(1, 8'h55, 1, 0, 1, 0, 1));
    vecs.push_back(mkvec(0, 8'h00, 1, 0, 0, 0, 1));
    vecs.push_back(mkvec(0, 8'h00, 0, 1, 0, 0, 0));

    foreach (vecs[i]) begin
      step_std(vecs[i].winc, vecs[i].wdata, vecs[i].rinc, vecs[i].clr);
      chk($sformatf("vec%0d count", i),     {27'd0, s_if.count}, vecs[i].cnt);
      chk($sformatf("vec%0d wfull", i),     {31'd0, s_if.wfull}, {31'd0, vecs[i].full});
      chk($sformatf("vec%0d wafull", i),    {31'd0, s_if.wafull}, {31'd0, vecs[i].afull});
      chk($sformatf("vec%0d rempty", i),    {31'd0, s_if.rempty}, {31'd0, vecs[i].empty});
      chk($sformatf("vec%0d raempty", i),   {31'd0, s_if.raempty}, {31'd0, vecs[i].aempty});
      chk($sformatf("vec%0d overflow", i),  {31'd0, s_if.overflow}, {31'd0, vecs[i].ovf});
      chk($sformatf("vec%0d underflow", i), {31'd0, s_if.underflow}, {31'd0, vecs[i].udf});
    end

    // FWFT: head word visible without a read request
    f_if.winc  = 1'b1;
    f_if.wdata = 8'h3C;
    @(posedge clk);
    #1;
    f_if.winc = 1'b0;
    chk("fwft rempty after write", {31'd0, f_if.rempty}, 0);
    chk("fwft rdata after write",  {24'd0, f_if.rdata}, 32'h3C);
    @(posedge clk);
    #1;
    chk("fwft rdata held", {24'd0, f_if.rdata}, 32'h3C);
    f_if.rinc = 1'b1;
    @(posedge clk);
    #1;
    f_if.rinc = 1'b0;
    chk("fwft rempty after read", {31'd0, f_if.rempty}, 1);
    chk("fwft count after read",  {27'd0, f_if.count}, 0);

    // Random concurrent push/pop, biased busy to wrap the pointers
    for (int i = 0; i < 40; i++) begin
      step_std($urandom_range(0, 99) < 85, DW'($urandom), $urandom_range(0, 99) < 85, 0);
      chk($sformatf("rand%0d count", i), {27'd0, s_if.count}, sb.size());
    end

    // Drain, clear errors, then build up to 9 entries for the reset test
    for (int i = 0; i < DEPTH + 1 && sb.size() > 0; i++) step_std(0, 8'h00, 1, 0);
    step_std(0, 8'h00, 0, 1);
    chk("drained count", {27'd0, s_if.count}, 0);
    for (int i = 0; i < 10; i++) step_std(1, DW'(8'h90 + i), 0, 0);
    step_std(0, 8'h00, 1, 0);
    chk("pre-reset count", {27'd0, s_if.count}, 9);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst count",   {27'd0, s_if.count}, 0);
    chk("async rst rempty",  {31'd0, s_if.rempty}, 1);
    chk("async rst raempty", {31'd0, s_if.raempty}, 1);
    chk("async rst rdata",   {24'd0, s_if.rdata}, 0);
    chk("async rst wafull",  {31'd0, s_if.wafull}, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step_std(1, 8'h77, 0, 0);
    chk("post-reset count", {27'd0, s_if.count}, 1);
    step_std(0, 8'h00, 1, 0);
    chk("post-reset empty", {31'd0, s_if.rempty}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
